// File: rtl/sr_pulse_arbiter.sv
// sr_pulse_arbiter: round-robin owner of a shared SR latch; drives S/R pulses and verifies Q.
// Optional SR_SKIP_REDUNDANT_EN: acknowledge without pulsing when Q already holds the target.
module sr_pulse_arbiter #(
    parameter int PULSE_W = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic op_a,
    input  logic req_b,
    input  logic op_b,
    input  logic Q,
    output logic S,
    output logic R,
    output logic ack_a,
    output logic ack_b,
    output logic err,
    output logic busy
);
    typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, ACK} state_t;
    state_t r_state, w_state_nx;
    logic [3:0] r_cnt, w_cnt_nx;
    logic r_tgt, w_tgt_nx, r_win, w_win_nx, r_last, w_last_nx, r_mis, w_mis_nx;
    logic w_pick, w_op;
    // r_win/r_last: 0 = A, 1 = B; on a tie the side that was not served last wins
    assign w_pick = (req_a && req_b) ? !r_last : req_b;
    assign w_op   = w_pick ? op_b : op_a;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_tgt   <= 1'b0;
            r_win   <= 1'b0;
            r_last  <= 1'b1;
            r_mis   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_tgt   <= w_tgt_nx;
            r_win   <= w_win_nx;
            r_last  <= w_last_nx;
            r_mis   <= w_mis_nx;
        end
    end
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_tgt_nx   = r_tgt;
        w_win_nx   = r_win;
        w_last_nx  = r_last;
        w_mis_nx   = r_mis;
        case (r_state)
            IDLE: if (req_a || req_b) begin
                w_win_nx  = w_pick;
                w_last_nx = w_pick;
                w_tgt_nx  = w_op;
                w_mis_nx  = 1'b0;
                w_cnt_nx  = 4'(PULSE_W - 1);
`ifdef SR_SKIP_REDUNDANT_EN
                w_state_nx = (w_op == Q) ? ACK : DRIVE;
`else
                w_state_nx = DRIVE;
`endif
            end
            DRIVE: if (r_cnt == 4'd0) w_state_nx = SETTLE;
                   else w_cnt_nx = r_cnt - 4'd1;
            SETTLE: begin
                w_mis_nx   = (Q != r_tgt);
                w_state_nx = ACK;
            end
            default: w_state_nx = IDLE;
        endcase
    end
    // outputs decode registered state only, so S and R can never overlap or glitch
    assign S     = (r_state == DRIVE) && r_tgt;
    assign R     = (r_state == DRIVE) && !r_tgt;
    assign ack_a = (r_state == ACK) && !r_win;
    assign ack_b = (r_state == ACK) && r_win;
    assign err   = (r_state == ACK) && r_mis;
    assign busy  = (r_state != IDLE);
endmodule

// File: tb/tb_sr_pulse_arbiter.sv
// tb_sr_pulse_arbiter: timeline model of each grant plus clocked SR latch model, with directed and random stimulus.
module tb_sr_pulse_arbiter;
    localparam int PW = 2;
    logic clk = 1'b0, rst_n = 1'b1;
    logic req_a = 1'b0, op_a = 1'b0, req_b = 1'b0, op_b = 1'b0;
    logic S, R, ack_a, ack_b, err, busy, Q;
    logic q_lat = 1'b0, stuck = 1'b0;
    int checks = 0, errors = 0;

    sr_pulse_arbiter #(.PULSE_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .req_a(req_a), .op_a(op_a), .req_b(req_b), .op_b(op_b),
        .Q(Q), .S(S), .R(R), .ack_a(ack_a), .ack_b(ack_b), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;
    assign Q = stuck ? 1'b0 : q_lat;
    always @(posedge clk) q_lat <= S ? 1'b1 : (R ? 1'b0 : q_lat);

    // model: m_t counts cycles since grant; 0..PW-1 pulse, PW settle, PW+1 ack
    bit m_busy = 0, m_win = 0, m_tgt = 0, m_mis = 0, m_last = 1;
    int m_t = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0;
            m_last <= 1;
        end else if (!m_busy) begin
            if (req_a || req_b) begin
                m_busy <= 1;
                m_win  <= (req_a && req_b) ? !m_last : req_b;
                m_last <= (req_a && req_b) ? !m_last : req_b;
                m_tgt  <= ((req_a && req_b) ? !m_last : req_b) ? op_b : op_a;
                m_mis  <= 0;
`ifdef SR_SKIP_REDUNDANT_EN
                m_t <= ((((req_a && req_b) ? !m_last : req_b) ? op_b : op_a) == Q) ? PW + 1 : 0;
`else
                m_t <= 0;
`endif
            end
        end else begin
            if (m_t == PW) m_mis <= (Q != m_tgt);
            if (m_t == PW + 1) m_busy <= 0;
            else m_t <= m_t + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("S", S, int'(m_busy && m_t < PW && m_tgt));
        chk("R", R, int'(m_busy && m_t < PW && !m_tgt));
        chk("ack_a", ack_a, int'(m_busy && m_t == PW + 1 && !m_win));
        chk("ack_b", ack_b, int'(m_busy && m_t == PW + 1 && m_win));
        chk("err", err, int'(m_busy && m_t == PW + 1 && m_mis));
        chk("busy", busy, int'(m_busy));
        chk("S_and_R", S & R, 0);
    end

    task automatic wait_ack(input bit who, output int lat, output int sc, output int rc,
                            output int oth, output bit e);
        lat = -1; sc = 0; rc = 0; oth = 0; e = 0;
        for (int i = 1; i <= 50 && lat < 0; i++) begin
            @(negedge clk);
            sc += int'(S);
            rc += int'(R);
            if (who ? ack_a : ack_b) oth++;
            if (who ? ack_b : ack_a) begin
                lat = i;
                e = err;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: no ack for requester %0d within 50 cycles", who);
        end
    endtask

    task automatic run_op(input bit who, input bit op, output int lat, output int sc,
                          output int rc, output int oth, output bit e);
        if (who) begin req_b = 1; op_b = op; end
        else begin req_a = 1; op_a = op; end
        wait_ack(who, lat, sc, rc, oth, e);
        req_a = 0;
        req_b = 0;
        @(negedge clk);
    endtask

    task automatic pair();
        int first = -1;
        bit ga = 0, gb = 0;
        req_a = 1; op_a = 1; req_b = 1; op_b = 0;
        for (int i = 0; i < 60 && !(ga && gb); i++) begin
            @(negedge clk);
            if (ack_a) begin if (first < 0) first = 0; ga = 1; req_a = 0; end
            if (ack_b) begin if (first < 0) first = 1; gb = 1; req_b = 0; end
        end
        chk("pair_first_is_A", first, 0);
        chk("pair_both_acked", int'(ga && gb), 1);
        req_a = 0; req_b = 0;
        @(negedge clk);
    endtask

    initial begin
        int lat, sc, rc, oth;
        bit e;
        #1 rst_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_S", S, 0);
        chk("rst_R", R, 0);
        rst_n = 1;
        @(negedge clk);
        // A sets from Q=0
        run_op(0, 1, lat, sc, rc, oth, e);
        chk("a_set_lat", lat, 4);
        chk("a_set_S_cycles", sc, 2);
        chk("a_set_R_cycles", rc, 0);
        chk("a_set_err", e, 0);
        chk("a_set_Q", Q, 1);
        // B resets from Q=1
        run_op(1, 0, lat, sc, rc, oth, e);
        chk("b_rst_lat", lat, 4);
        chk("b_rst_R_cycles", rc, 2);
        chk("b_rst_S_cycles", sc, 0);
        chk("b_rst_no_ack_a", oth, 0);
        chk("b_rst_err", e, 0);
        chk("b_rst_Q", Q, 0);
        pair();
        pair();
        // reset during the second pulse cycle
        req_a = 1; op_a = !Q;
        @(negedge clk);
        @(negedge clk);
        chk("mid_drive_S", S, int'(op_a));
        #2 rst_n = 0;
        #1;
        chk("abort_S", S, 0);
        chk("abort_R", R, 0);
        chk("abort_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        wait_ack(0, lat, sc, rc, oth, e);
        chk("regrant_err", e, 0);
        req_a = 0;
        @(negedge clk);
        // Q stuck low
        stuck = 1;
        run_op(0, 1, lat, sc, rc, oth, e);
        chk("stuck_lat", lat, 4);
        chk("stuck_err", e, 1);
        stuck = 0;
        run_op(0, !Q, lat, sc, rc, oth, e);
        chk("clean_err", e, 0);
        // redundant set
        run_op(0, 1, lat, sc, rc, oth, e);
        run_op(0, 1, lat, sc, rc, oth, e);
`ifdef SR_SKIP_REDUNDANT_EN
        chk("redundant_lat", lat, 1);
        chk("redundant_S_cycles", sc, 0);
`else
        chk("redundant_lat", lat, 4);
        chk("redundant_S_cycles", sc, 2);
`endif
        chk("redundant_err", e, 0);
        // random traffic
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (ack_a) req_a = 0;
            else if (!req_a && $urandom_range(3) == 0) begin req_a = 1; op_a = 1'($urandom); end
            else if (req_a && $urandom_range(3) == 0) op_a = 1'($urandom);
            if (ack_b) req_b = 0;
            else if (!req_b && $urandom_range(3) == 0) begin req_b = 1; op_b = 1'($urandom); end
            else if (req_b && $urandom_range(3) == 0) op_b = 1'($urandom);
            if ($urandom_range(15) == 0) stuck = !stuck;
        end
        req_a = 0; req_b = 0; stuck = 0;
        repeat (20) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sr_pulse_arbiter.md
Name: sr_pulse_arbiter

Overview:
- Shares one SR latch (inputs S, R; outputs Q, Qn) between two requesters, A and B.
- Each requester asks for the latch to be set or reset. The arbiter grants requesters in round-robin order and drives a clean S or R pulse of programmable width.
- The arbiter never drives the forbidden S=R=1 combination.
- After each pulse it reads Q back and reports completion or error to the granted requester.
- It sits between the control logic and the latch instance, which is the latch's only driver.

Parameters:
- PULSE_W, 2, number of clock cycles S or R is held high per operation; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_a  input  1  requester A request; held high until ack_a.
- op_a  input  1  requester A operation: 1 = set (Q->1), 0 = reset (Q->0). Sampled at grant.
- req_b  input  1  requester B request; same rules as req_a.
- op_b  input  1  requester B operation; same encoding as op_a.
- Q  input  1  latch output fed back for verification.
- S  output  1  latch set drive.
- R  output  1  latch reset drive.
- ack_a  output  1  one-cycle completion pulse to A.
- ack_b  output  1  one-cycle completion pulse to B.
- err  output  1  high together with an ack pulse when Q did not reach the target value.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low.
- Reset values (asserted immediately while rst_n=0):
  - S=0, R=0, ack_a=0, ack_b=0, err=0, busy=0.
  - state=IDLE, pulse counter=0.
  - last_grant=B, so A wins the first tie.
- States: IDLE -> DRIVE -> SETTLE -> ACK -> IDLE.
- IDLE:
  - At a rising edge with any req high, select the winner and register op_x as target. Enter DRIVE with counter=PULSE_W-1.
  - Only one request: that requester wins.
  - Both requests: the requester not equal to last_grant wins, and last_grant is updated to the winner.
- DRIVE:
  - S = target, R = !target. Both are decoded from registered state, so they are glitch-free.
  - Counter decrements each cycle. When counter=0, move to SETTLE.
  - S/R are therefore high for exactly PULSE_W cycles.
- SETTLE: S=R=0 for one cycle. At its closing edge, capture mismatch = (Q != target).
- ACK:
  - ack_x=1 for exactly one cycle for the winner only. err = captured mismatch in the same cycle.
  - Then return to IDLE.
- Latency: with a request sampled at edge k:
  - S/R are high during cycles k+1 .. k+PULSE_W.
  - SETTLE is cycle k+PULSE_W+1.
  - ACK is cycle k+PULSE_W+2.
  - Total: PULSE_W+2 cycles from grant to ack.
- Request handling:
  - Requesters must drop req in the cycle after ack.
  - A req still high when the arbiter is back in IDLE is treated as a new request.
  - Changes to req/op of the granted requester after grant are ignored.
  - Requests from the losing requester are held off until IDLE. They are never dropped.
- Invariant: S & R is never 1, in any state or during reset.
- Reset mid-operation: S/R are deasserted in the same instant as the reset. No ack is issued for the aborted operation. After release, service resumes from IDLE with A priority.
- Back-to-back: with both req held continuously, grants alternate A,B,A,B… with one IDLE cycle between operations.

Optional Feature:
- Macro: SR_SKIP_REDUNDANT_EN.
- Defined: in IDLE, if the winner's op already equals Q, skip DRIVE and SETTLE, go directly to ACK the next cycle (ack 1 cycle after grant), err=0, and keep S=R=0 throughout. Round-robin update is unchanged.
- Undefined: every operation drives its pulse regardless of Q.

Test Plan:
- A alone, op_a=1, Q starts 0, PULSE_W=2 -> S high exactly 2 cycles, R=0 throughout, ack_a at grant+4, err=0, Q=1.
- B alone, op_b=0, Q=1 -> R high 2 cycles, ack_b at grant+4, err=0, Q=0, ack_a never asserted.
- req_a=1 (op=1) and req_b=1 (op=0) asserted together after reset, both held until their own ack:
  - order is A then B.
  - a second simultaneous pair gives A then B again, because last_grant alternates.
  - S&R==0 checked every cycle.
- rst_n pulled low during the 2nd DRIVE cycle -> S/R drop to 0 asynchronously, no ack; after release a held req_a is re-granted normally.
- Bench forces Q stuck at 0, op_a=1 -> ack_a with err=1 in the same cycle; err=0 on the next clean operation.
- With SR_SKIP_REDUNDANT_EN defined, Q=1 and op_a=1 -> ack_a 1 cycle after grant, S never asserted, err=0. Without the macro, a 2-cycle S pulse occurs.
